hpdmc_dqseq: RTL



---
 rtl/hpdmc_dqseq_if.sv | 28 ++
 rtl/hpdmc_dqseq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_dqseq_if.sv
// hpdmc_dqseq_if: the command and data bundle between the SDRAM controller
// core, the DQ sequencer and the DQ tristate buffer bank.
// master = controller core plus pad side, slave = the sequencer.
interface hpdmc_dqseq_if #(
    parameter int DW = 32
);
    logic          wr_start;
    logic          rd_start;
    logic [DW-1:0] wr_data;
    logic          wr_next;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          cmd_err;
    logic [DW-1:0] dq_t;
    logic [DW-1:0] dq_i;
    logic [DW-1:0] dq_o;

    modport master (
        output wr_start, rd_start, wr_data, dq_o,
        input  wr_next, rd_data, rd_valid, busy, cmd_err, dq_t, dq_i
    );

    modport slave (
        input  wr_start, rd_start, wr_data, dq_o,
        output wr_next, rd_data, rd_valid, busy, cmd_err, dq_t, dq_i
    );
endinterface

// File: rtl/hpdmc_dqseq.sv
// hpdmc_dqseq: DQ data-path sequencer for the SDRAM controller.
// Drives the tristate enables and output data of the DQ buffer bank for write
// bursts, captures read beats after the CAS latency, and forces a bus
// turnaround gap between a read burst and a following write burst.
// Optional feature macro: HPDMC_DQSEQ_RDREG_EN adds a pad-side capture flop
// on dq_o, delaying read data (and the READ/TURN phases) by one cycle.
module hpdmc_dqseq #(
    parameter int DW    = 32,
    parameter int BURST = 4,
    parameter int CL    = 2,
    parameter int TURN  = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    hpdmc_dqseq_if.slave       bus
);

`ifdef HPDMC_DQSEQ_RDREG_EN
    localparam int CAP_DLY = 1;
`else
    localparam int CAP_DLY = 0;
`endif

    // RDWAIT ends on the cycle whose capture source holds beat 0.
    localparam int WAIT_LAST = CL - 1 + CAP_DLY;
    localparam int M1        = ((BURST - 1) > WAIT_LAST) ? (BURST - 1) : WAIT_LAST;
    localparam int CNT_MAX   = ((TURN - 1) > M1) ? (TURN - 1) : M1;
    localparam int CW        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);
    localparam logic [CW-1:0] WAIT_END   = CW'(WAIT_LAST);
    localparam logic [CW-1:0] TURN_LAST  = CW'((TURN > 0) ? (TURN - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_TURN   = 3'd2,
        S_RDWAIT = 3'd3,
        S_READ   = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          wr_pop;
    logic          cap_en;
    logic          reject;
    logic          busy_c;

    logic [DW-1:0] dq_t_reg;
    logic [DW-1:0] dq_i_reg;
    logic [DW-1:0] rd_data_reg;
    logic          rd_valid_reg;
    logic          cmd_err_reg;
    logic [DW-1:0] cap_src;

`ifdef HPDMC_DQSEQ_RDREG_EN
    logic [DW-1:0] dq_o_pad_reg;

    // Pad-side flop: the fabric capture register then samples this copy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_o_pad_reg <= '0;
        end else begin
            dq_o_pad_reg <= bus.dq_o;
        end
    end

    assign cap_src = dq_o_pad_reg;
`else
    assign cap_src = bus.dq_o;
`endif

    // State and beat counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic plus the per-cycle strobes (pop, capture, reject, busy).
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_pop     = 1'b0;
        cap_en     = 1'b0;
        reject     = 1'b0;
        busy_c     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Simultaneous starts are ambiguous, so neither is taken.
                if (bus.wr_start && bus.rd_start) begin
                    reject = 1'b1;
                end else if (bus.wr_start) begin
                    wr_pop     = 1'b1;
                    state_next = S_WRITE;
                    cnt_next   = '0;
                end else if (bus.rd_start) begin
                    state_next = S_RDWAIT;
                    cnt_next   = '0;
                end
            end

            S_WRITE: begin
                // Beat 0 was popped in the accept cycle; pop the remaining
                // BURST-1 here, the final cycle only drives the last beat.
                busy_c = 1'b1;
                reject = bus.wr_start | bus.rd_start;
                wr_pop = (cnt_reg != BURST_LAST);
                if (cnt_reg == BURST_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_RDWAIT: begin
                busy_c = 1'b1;
                reject = bus.wr_start | bus.rd_start;
                if (cnt_reg == WAIT_END) begin
                    cap_en     = 1'b1;
                    state_next = S_READ;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_READ: begin
                // READ spans the rd_valid cycles; capture of the next beat
                // happens in every cycle but the last.
                busy_c = 1'b1;
                reject = bus.wr_start | bus.rd_start;
                cap_en = (cnt_reg != BURST_LAST);
                if (cnt_reg == BURST_LAST) begin
                    state_next = (TURN > 0) ? S_TURN : S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_TURN: begin
                // Reads cannot collide with read data on the bus, so only
                // writes are held off during the turnaround.
                busy_c = bus.wr_start;
                reject = bus.wr_start;
                if (bus.rd_start) begin
                    state_next = S_RDWAIT;
                    cnt_next   = '0;
                end else if (cnt_reg == TURN_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pad drive, read capture and error pulse registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_t_reg     <= '1;
            dq_i_reg     <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            cmd_err_reg  <= 1'b0;
        end else begin
            dq_t_reg     <= {DW{~wr_pop}};
            rd_valid_reg <= cap_en;
            cmd_err_reg  <= reject;
            if (wr_pop) begin
                dq_i_reg <= bus.wr_data;
            end
            if (cap_en) begin
                rd_data_reg <= cap_src;
            end
        end
    end

    assign bus.wr_next  = wr_pop;
    assign bus.busy     = busy_c;
    assign bus.dq_t     = dq_t_reg;
    assign bus.dq_i     = dq_i_reg;
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.cmd_err  = cmd_err_reg;

endmodule
